// File: rtl/pipelined_bubble_sorter_if.sv
// ---------------------------------------------------------------------------
// pipelined_bubble_sorter_if
//
// Bundles the input and output handshakes of pipelined_bubble_sorter.
//
// Handshake semantics (both sides): a transfer happens on a rising clock
// edge where valid and ready are both high. The producer holds its payload
// while valid is high and ready is low. Ready may depend combinationally on
// the downstream ready (i_ready follows o_ready through the pipeline).
//
// Signals:
//   i_data  [N*W] input vector, element k at i_data[k*W +: W]
//   i_desc        sort direction, 0 = ascending, 1 = descending
//   i_valid       input payload valid
//   i_ready       sorter accepts input this cycle
//   o_data  [N*W] sorted vector, element 0 first in sort order
//   o_valid       o_data valid
//   o_ready       downstream accepts output
//   o_tag   [N*T] original input index per output slot (SORTER_TAG_EN only)
//
// Modports: master = the side that drives inputs and consumes outputs,
//           slave  = the sorter itself.
// ---------------------------------------------------------------------------
interface pipelined_bubble_sorter_if #(
    parameter int N = 4,
    parameter int W = 4
);
    localparam int T = (N > 1) ? $clog2(N) : 1;

    logic [N*W-1:0] i_data;
    logic           i_desc;
    logic           i_valid;
    logic           i_ready;
    logic [N*W-1:0] o_data;
    logic           o_valid;
    logic           o_ready;
`ifdef SORTER_TAG_EN
    logic [N*T-1:0] o_tag;

    modport master (
        output i_data, i_desc, i_valid, o_ready,
        input  i_ready, o_data, o_valid, o_tag
    );
    modport slave (
        input  i_data, i_desc, i_valid, o_ready,
        output i_ready, o_data, o_valid, o_tag
    );
`else
    modport master (
        output i_data, i_desc, i_valid, o_ready,
        input  i_ready, o_data, o_valid
    );
    modport slave (
        input  i_data, i_desc, i_valid, o_ready,
        output i_ready, o_data, o_valid
    );
`endif
endinterface

// File: rtl/pipelined_bubble_sorter.sv
// ---------------------------------------------------------------------------
// pipelined_bubble_sorter
//
// Fully pipelined bubble sorter: one vector of N signed W-bit elements per
// clock, each vector sorted ascending or descending by its own flag. There
// are N-1 register stages; stage s (1-based) does one bubble pass over
// positions 0..N-s, so after it positions N-s..N-1 are final.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset; clears every stage register
//   bus  pipelined_bubble_sorter_if.slave (input and output handshakes)
//
// The whole pipeline moves together: adv = ~o_valid | o_ready. When adv is
// low every stage holds (bubbles are not squeezed out), and i_ready = adv.
//
// Optional feature: define SORTER_TAG_EN to carry a per-element tag holding
// the element's original input index, swapped together with the data and
// presented on bus.o_tag. Data behaviour is the same in both builds.
// ---------------------------------------------------------------------------
module pipelined_bubble_sorter #(
    parameter int N = 4,
    parameter int W = 4
) (
    input logic                    clk,
    input logic                    rst,
    pipelined_bubble_sorter_if.slave bus
);
    localparam int S = N - 1;
    localparam int T = (N > 1) ? $clog2(N) : 1;

    // Stage registers, index i holds stage i+1.
    logic [N*W-1:0] stg_data  [S];
    logic           stg_desc  [S];
    logic           stg_valid [S];

    // Inputs of each stage: the module input for stage 1, else the
    // previous stage's register.
    logic [N*W-1:0] src_data  [S];
    logic           src_desc  [S];
    logic           src_valid [S];

    // Result of each stage's bubble pass, loaded on adv.
    logic [N*W-1:0] pass_data [S];

`ifdef SORTER_TAG_EN
    logic [N*T-1:0] stg_tag   [S];
    logic [N*T-1:0] src_tag   [S];
    logic [N*T-1:0] pass_tag  [S];
`endif

    logic adv;

    assign adv         = ~stg_valid[S-1] | bus.o_ready;
    assign bus.i_ready = adv;
    assign bus.o_data  = stg_data[S-1];
    assign bus.o_valid = stg_valid[S-1];
`ifdef SORTER_TAG_EN
    assign bus.o_tag   = stg_tag[S-1];
`endif

    always_comb begin : stage_sources
        src_data[0]  = bus.i_data;
        src_desc[0]  = bus.i_desc;
        src_valid[0] = bus.i_valid;
        for (int i = 1; i < S; i++) begin
            src_data[i]  = stg_data[i-1];
            src_desc[i]  = stg_desc[i-1];
            src_valid[i] = stg_valid[i-1];
        end
`ifdef SORTER_TAG_EN
        // Tags start as the input index of each element.
        src_tag[0] = '0;
        for (int k = 0; k < N; k++) begin
            src_tag[0][k*T +: T] = T'(k);
        end
        for (int i = 1; i < S; i++) begin
            src_tag[i] = stg_tag[i-1];
        end
`endif
    end

    // One bubble pass per stage. The compare-swaps run as a chain in
    // increasing j, so an element can travel the whole range in one stage.
    // Strict compares keep equal elements in place, which makes the sort
    // stable.
    always_comb begin : bubble_pass
        logic signed [W-1:0] v [N];
        logic signed [W-1:0] tmp;
`ifdef SORTER_TAG_EN
        logic [T-1:0] tv [N];
        logic [T-1:0] tmp_t;
`endif
        tmp = '0;
        for (int k = 0; k < N; k++) begin
            v[k] = '0;
        end
`ifdef SORTER_TAG_EN
        tmp_t = '0;
        for (int k = 0; k < N; k++) begin
            tv[k] = '0;
        end
`endif
        for (int i = 0; i < S; i++) begin
            pass_data[i] = '0;
`ifdef SORTER_TAG_EN
            pass_tag[i] = '0;
`endif
        end

        for (int i = 0; i < S; i++) begin
            for (int k = 0; k < N; k++) begin
                v[k] = src_data[i][k*W +: W];
`ifdef SORTER_TAG_EN
                tv[k] = src_tag[i][k*T +: T];
`endif
            end
            // Stage i+1 covers positions 0..N-1-i, i.e. pairs j < N-1-i.
            for (int j = 0; j < N - 1; j++) begin
                if (j < N - 1 - i) begin
                    if (src_desc[i] ? (v[j] < v[j+1]) : (v[j] > v[j+1])) begin
                        tmp    = v[j];
                        v[j]   = v[j+1];
                        v[j+1] = tmp;
`ifdef SORTER_TAG_EN
                        tmp_t   = tv[j];
                        tv[j]   = tv[j+1];
                        tv[j+1] = tmp_t;
`endif
                    end
                end
            end
            for (int k = 0; k < N; k++) begin
                pass_data[i][k*W +: W] = v[k];
`ifdef SORTER_TAG_EN
                pass_tag[i][k*T +: T] = tv[k];
`endif
            end
        end
    end

    // Reset takes priority over adv. Data of invalid stages still loads on
    // adv; it is simply never presented as valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < S; i++) begin
                stg_data[i]  <= '0;
                stg_desc[i]  <= 1'b0;
                stg_valid[i] <= 1'b0;
`ifdef SORTER_TAG_EN
                stg_tag[i]   <= '0;
`endif
            end
        end else if (adv) begin
            for (int i = 0; i < S; i++) begin
                stg_data[i]  <= pass_data[i];
                stg_desc[i]  <= src_desc[i];
                stg_valid[i] <= src_valid[i];
`ifdef SORTER_TAG_EN
                stg_tag[i]   <= pass_tag[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_pipelined_bubble_sorter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_bubble_sorter
//
// Self-checking bench for pipelined_bubble_sorter with N=4, W=4. Directed
// table vectors with hand-computed results, hand-written sequences for
// back-to-back traffic, backpressure and mid-stream reset, and a randomized
// phase checked against a stable selection-sort reference model.
// ---------------------------------------------------------------------------
module tb_pipelined_bubble_sorter;
    localparam int N = 4;
    localparam int W = 4;
    localparam int T = 2;

    logic clk;
    logic rst;

    pipelined_bubble_sorter_if #(.N(N), .W(W)) bus ();

    pipelined_bubble_sorter #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    logic [N*W-1:0] exp_q  [$];
    logic [N*T-1:0] exp_tq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
    endfunction

    function automatic logic [N*T-1:0] packt(input int t0, input int t1, input int t2, input int t3);
        return {2'(t3), 2'(t2), 2'(t1), 2'(t0)};
    endfunction

    // Reference model: stable selection sort. Each output slot takes the
    // earliest remaining element with the smallest (ascending) or largest
    // (descending) signed value; the tag is that element's input index.
    function automatic void model(input logic [N*W-1:0] d, input logic desc,
                                  output logic [N*W-1:0] sd, output logic [N*T-1:0] st);
        int vals [N];
        bit used [N];
        int best;
        for (int k = 0; k < N; k++) begin
            vals[k] = int'($signed(d[k*W +: W]));
            used[k] = 1'b0;
        end
        sd = '0;
        st = '0;
        for (int slot = 0; slot < N; slot++) begin
            best = -1;
            for (int k = 0; k < N; k++) begin
                if (!used[k]) begin
                    if (best < 0) best = k;
                    else if (desc ? (vals[k] > vals[best]) : (vals[k] < vals[best])) best = k;
                end
            end
            used[best] = 1'b1;
            sd[slot*W +: W] = W'(vals[best]);
            st[slot*T +: T] = T'(best);
        end
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge; drives one cycle, checks the output side against
    // the scoreboard, records an accepted input, returns at the next negedge.
    task automatic step(input logic v, input logic [N*W-1:0] d, input logic desc, input logic ordy);
        logic [N*W-1:0] sd;
        logic [N*T-1:0] st;
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_desc  = desc;
        bus.o_ready = ordy;
        #1;
        if (bus.o_valid && bus.o_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(bus.o_data), 32'hdead);
            end else begin
                check("sb_data", 32'(bus.o_data), 32'(exp_q.pop_front()));
`ifdef SORTER_TAG_EN
                check("sb_tag", 32'(bus.o_tag), 32'(exp_tq.pop_front()));
`else
                void'(exp_tq.pop_front());
`endif
            end
        end else if (bus.o_valid && !bus.o_ready) begin
            check("stall_i_ready", 32'(bus.i_ready), 32'd0);
            if (exp_q.size() != 0) check("stall_data", 32'(bus.o_data), 32'(exp_q[0]));
        end
        if (bus.i_valid && bus.i_ready) begin
            model(d, desc, sd, st);
            exp_q.push_back(sd);
            exp_tq.push_back(st);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            step(1'b0, '0, 1'b0, 1'b1);
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [N*W-1:0] data;
        logic           desc;
        logic [N*W-1:0] exp_data;
        logic [N*T-1:0] exp_tag;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int base;

        tbl[0] = '{pack4(3, -2, 7, 0),   1'b0, pack4(-2, 0, 3, 7),   packt(1, 3, 0, 2)};
        tbl[1] = '{pack4(3, -2, 7, 0),   1'b1, pack4(7, 3, 0, -2),   packt(2, 0, 3, 1)};
        tbl[2] = '{pack4(-8, 7, -1, 1),  1'b0, pack4(-8, -1, 1, 7),  packt(0, 2, 3, 1)};
        tbl[3] = '{pack4(-8, 7, -1, 1),  1'b1, pack4(7, 1, -1, -8),  packt(1, 3, 2, 0)};
        tbl[4] = '{pack4(7, 6, 5, 4),    1'b0, pack4(4, 5, 6, 7),    packt(3, 2, 1, 0)};
        tbl[5] = '{pack4(5, 5, 2, 5),    1'b0, pack4(2, 5, 5, 5),    packt(2, 0, 1, 3)};
        tbl[6] = '{pack4(0, -8, -8, 7),  1'b1, pack4(7, 0, -8, -8),  packt(3, 0, 1, 2)};

        // Reset and post-reset state.
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_desc  = 1'b0;
        bus.o_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_o_valid", 32'(bus.o_valid), 32'd0);
        check("rst_o_data",  32'(bus.o_data),  32'd0);
        check("rst_i_ready", 32'(bus.i_ready), 32'd1);
`ifdef SORTER_TAG_EN
        check("rst_o_tag",   32'(bus.o_tag),   32'd0);
`endif
        @(negedge clk);

        // Table: one vector at a time, checking latency and result.
        for (int i = 0; i < 7; i++) begin
            bus.i_valid = 1'b1;
            bus.i_data  = tbl[i].data;
            bus.i_desc  = tbl[i].desc;
            bus.o_ready = 1'b1;
            #1;
            check("tbl_i_ready", 32'(bus.i_ready), 32'd1);
            @(posedge clk);          // accepted at edge t
            @(negedge clk);
            bus.i_valid = 1'b0;
            bus.i_data  = '0;
            @(posedge clk);          // edge t+1
            @(negedge clk);
            check("tbl_lat_early", 32'(bus.o_valid), 32'd0);
            @(posedge clk);          // edge t+2
            @(negedge clk);
            check("tbl_lat_valid", 32'(bus.o_valid), 32'd1);
            check("tbl_data", 32'(bus.o_data), 32'(tbl[i].exp_data));
`ifdef SORTER_TAG_EN
            check("tbl_tag", 32'(bus.o_tag), 32'(tbl[i].exp_tag));
`endif
            @(posedge clk);          // consumed
            @(negedge clk);
        end

        // Back-to-back vectors with alternating direction: one output per cycle.
        base = n_out;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, N*W'($urandom), 1'(i % 2), 1'b1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1);
        check("b2b_throughput", 32'(n_out - base), 32'd6);
        drain();

        // Backpressure: fill with o_ready low, stall 5 cycles, then release.
        base = n_out;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, N*W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_o_valid", 32'(bus.o_valid), 32'd1);
            step(1'b1, N*W'($urandom), 1'b0, 1'b0);
        end
        check("bp_held_count", 32'(exp_q.size()), 32'd3);
        drain();
        check("bp_out_count", 32'(n_out - base), 32'd3);

        // Reset with three vectors in flight: all are discarded.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, N*W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        rst = 1'b1;
        bus.i_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_o_valid", 32'(bus.o_valid), 32'd0);
        check("mid_rst_o_data",  32'(bus.o_data),  32'd0);
        check("mid_rst_i_ready", 32'(bus.i_ready), 32'd1);
        exp_q.delete();
        exp_tq.delete();
        @(negedge clk);
        base = n_out;
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, 1'b1);
        check("mid_rst_no_stale", 32'(n_out - base), 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), N*W'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
